// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: FETCH -> WAIT_MEM -> EXECUTE, with a sticky TRAP state.
// Optional retirement statistics are built when PC_FETCH_STATS_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic        instrValid,
    input  logic        execDone,
    input  logic        nextPCSource,
    input  logic [31:0] branchTarget,
    output logic [31:0] pcCurrent,
    output logic [31:0] pcPlus4,
    output logic        trap,
    output logic [1:0]  trapCause,
    output logic [31:0] retiredCount,
    output logic [31:0] takenCount
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_MEM = 2'd1,
        EXECUTE  = 2'd2,
        TRAP     = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg, pc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic [31:0]       instr_reg, instr_next;
    logic              valid_reg, valid_next;
    logic              trap_reg, trap_next;
    logic [1:0]        cause_reg, cause_next;

    logic [31:0]       target_aligned;
    logic [31:0]       seq_pc;
    logic [31:0]       candidate_pc;
    logic              retire_ok;

    // Branch targets are halfword-aligned by clearing bit 0; bit 1 set means a misaligned word target.
    assign target_aligned = branchTarget & ~32'd1;
    assign seq_pc         = pc_reg + 32'd4;
    assign candidate_pc   = nextPCSource ? target_aligned : seq_pc;
    assign retire_ok      = (state_reg == EXECUTE) && execDone && !candidate_pc[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_VECTOR;
            cnt_reg   <= '0;
            req_reg   <= 1'b0;
            instr_reg <= 32'd0;
            valid_reg <= 1'b0;
            trap_reg  <= 1'b0;
            cause_reg <= CAUSE_NONE;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            trap_reg  <= trap_next;
            cause_reg <= cause_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        req_next   = req_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        trap_next  = trap_reg;
        cause_next = cause_reg;

        unique case (state_reg)
            FETCH: begin
                req_next = 1'b0;
                if (!stall) begin
                    req_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                req_next = 1'b1;
                // A ready response on the final allowed cycle still completes the fetch.
                if (imemReady) begin
                    instr_next = imemData;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    state_next = EXECUTE;
                end else if (cnt_reg == CNT_LAST) begin
                    req_next   = 1'b0;
                    trap_next  = 1'b1;
                    cause_next = CAUSE_TIMEOUT;
                    state_next = TRAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            EXECUTE: begin
                if (execDone) begin
                    if (candidate_pc[1]) begin
                        valid_next = 1'b0;
                        trap_next  = 1'b1;
                        cause_next = CAUSE_MISALIGN;
                        state_next = TRAP;
                    end else begin
                        pc_next    = candidate_pc;
                        valid_next = 1'b0;
                        state_next = FETCH;
                    end
                end
            end
            TRAP: begin
                req_next   = 1'b0;
                valid_next = 1'b0;
                trap_next  = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    assign imemReq    = req_reg;
    assign imemAddr   = pc_reg;
    assign instr      = instr_reg;
    assign instrValid = valid_reg;
    assign pcCurrent  = pc_reg;
    assign pcPlus4    = seq_pc;
    assign trap       = trap_reg;
    assign trapCause  = cause_reg;

`ifdef PC_FETCH_STATS_EN
    logic [31:0] retired_reg;
    logic [31:0] taken_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_reg <= 32'd0;
            taken_reg   <= 32'd0;
        end else if (retire_ok) begin
            retired_reg <= retired_reg + 32'd1;
            if (nextPCSource) begin
                taken_reg <= taken_reg + 32'd1;
            end
        end
    end

    assign retiredCount = retired_reg;
    assign takenCount   = taken_reg;
`else
    logic unused_stats;
    assign unused_stats = retire_ok;
    assign retiredCount = 32'd0;
    assign takenCount   = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: fetch/retire sequencing, traps, stall, wrap, async reset, stats.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic        instrValid;
    logic        execDone;
    logic        nextPCSource;
    logic [31:0] branchTarget;
    logic [31:0] pcCurrent;
    logic [31:0] pcPlus4;
    logic        trap;
    logic [1:0]  trapCause;
    logic [31:0] retiredCount;
    logic [31:0] takenCount;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemData    (imemData),
        .instr       (instr),
        .instrValid  (instrValid),
        .execDone    (execDone),
        .nextPCSource(nextPCSource),
        .branchTarget(branchTarget),
        .pcCurrent   (pcCurrent),
        .pcPlus4     (pcPlus4),
        .trap        (trap),
        .trapCause   (trapCause),
        .retiredCount(retiredCount),
        .takenCount  (takenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic hold_stall);
        stall = hold_stall;
        rst = 1'b1;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Assumes FETCH with stall low: issue, then answer on the first WAIT_MEM cycle.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        tick();
        check("fetch_req", {31'd0, imemReq}, 32'd1);
        check("fetch_addr", imemAddr, exp_addr);
        imemReady = 1'b1;
        imemData  = data;
        tick();
        imemReady = 1'b0;
        check("fetch_valid", {31'd0, instrValid}, 32'd1);
        check("fetch_instr", instr, data);
    endtask

    task automatic retire(input logic src, input logic [31:0] tgt);
        execDone     = 1'b1;
        nextPCSource = src;
        branchTarget = tgt;
        tick();
        execDone     = 1'b0;
        nextPCSource = 1'b0;
        branchTarget = 32'hDEAD_BEEF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; imemReady = 1'b0; imemData = 32'd0;
        execDone = 1'b0; nextPCSource = 1'b0; branchTarget = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'd0, imemReq},    32'd0);
        check("rst_valid", {31'd0, instrValid}, 32'd0);
        check("rst_trap",  {31'd0, trap},       32'd0);
        check("rst_cause", {30'd0, trapCause},  32'd0);
        check("rst_pc",    pcCurrent,           32'd0);
        check("rst_instr", instr,               32'd0);
        rst = 1'b0;

        // First fetch, held in EXECUTE for two idle cycles.
        fetch(32'h0000_0000, 32'h0050_0093);
        check("first_req_drop", {31'd0, imemReq}, 32'd0);
        tick(); tick();
        check("exec_hold_valid", {31'd0, instrValid}, 32'd1);
        retire(1'b1, 32'h0000_0100);
        check("br_pc_100", pcCurrent, 32'h0000_0100);
        check("br_valid_clr", {31'd0, instrValid}, 32'd0);

        // Sequential retire from 0x100.
        fetch(32'h0000_0100, 32'h1111_1111);
        retire(1'b0, 32'h0000_0000);
        check("seq_pc", pcCurrent, 32'h0000_0104);
        check("seq_pc4", pcPlus4, 32'h0000_0108);

        // Taken branch with bit0 set, then a misaligned target.
        fetch(32'h0000_0104, 32'h2222_2222);
        retire(1'b1, 32'h0000_0FF1);
        check("br_clr_bit0", pcCurrent, 32'h0000_0FF0);
        check("br_no_trap", {31'd0, trap}, 32'd0);
        fetch(32'h0000_0FF0, 32'h3333_3333);
        retire(1'b1, 32'h0000_0202);
        check("mis_trap",  {31'd0, trap},      32'd1);
        check("mis_cause", {30'd0, trapCause}, 32'd1);
        check("mis_pc",    pcCurrent,          32'h0000_0FF0);
        check("mis_req",   {31'd0, imemReq},   32'd0);
        check("mis_valid", {31'd0, instrValid}, 32'd0);
        imemReady = 1'b1; execDone = 1'b1; nextPCSource = 1'b1; branchTarget = 32'h40;
        tick(); tick();
        imemReady = 1'b0; execDone = 1'b0; nextPCSource = 1'b0;
        check("trap_hold_pc",  pcCurrent,         32'h0000_0FF0);
        check("trap_hold_req", {31'd0, imemReq},  32'd0);
        check("trap_hold",     {31'd0, trap},     32'd1);

        // Timeout: 15 waiting cycles are tolerated, the 16th traps.
        do_reset(1'b0);
        tick();
        check("to_req", {31'd0, imemReq}, 32'd1);
        repeat (15) tick();
        check("to_not_yet", {31'd0, trap}, 32'd0);
        check("to_req_held", {31'd0, imemReq}, 32'd1);
        tick();
        check("to_trap",  {31'd0, trap},      32'd1);
        check("to_cause", {30'd0, trapCause}, 32'd2);
        check("to_req_0", {31'd0, imemReq},   32'd0);

        // Ready on the final allowed cycle wins over the timeout.
        do_reset(1'b0);
        tick();
        repeat (15) tick();
        imemReady = 1'b1; imemData = 32'hCAFE_F00D;
        tick();
        imemReady = 1'b0;
        check("race_trap",  {31'd0, trap},       32'd0);
        check("race_valid", {31'd0, instrValid}, 32'd1);
        check("race_instr", instr,               32'hCAFE_F00D);

        // Stall holds FETCH without requesting.
        do_reset(1'b1);
        repeat (5) tick();
        check("stall_req", {31'd0, imemReq}, 32'd0);
        stall = 1'b0;
        tick();
        check("unstall_req", {31'd0, imemReq}, 32'd1);
        imemReady = 1'b1; imemData = 32'h0000_0013;
        tick();
        imemReady = 1'b0;

        // PC wrap at the top of the address space.
        retire(1'b1, 32'hFFFF_FFFC);
        check("wrap_pc",  pcCurrent, 32'hFFFF_FFFC);
        check("wrap_pc4", pcPlus4,   32'h0000_0000);
        fetch(32'hFFFF_FFFC, 32'h4444_4444);
        retire(1'b0, 32'h0000_0000);
        check("wrap_pc0",   pcCurrent,          32'h0000_0000);
        check("wrap_ntrap", {31'd0, trap},      32'd0);

        // Asynchronous reset between edges during WAIT_MEM.
        fetch(32'h0000_0000, 32'h5555_5555);
        retire(1'b0, 32'h0000_0000);
        tick();
        check("pre_arst_req",  {31'd0, imemReq}, 32'd1);
        check("pre_arst_addr", imemAddr,         32'h0000_0004);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req",  {31'd0, imemReq}, 32'd0);
        check("arst_addr", imemAddr,         32'h0000_0000);
        check("arst_pc4",  pcPlus4,          32'h0000_0004);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Retirement statistics: taken, sequential, taken.
        fetch(32'h0000_0000, 32'h6666_6666);
        retire(1'b1, 32'h0000_0040);
        fetch(32'h0000_0040, 32'h7777_7777);
        retire(1'b0, 32'h0000_0000);
        fetch(32'h0000_0044, 32'h8888_8888);
        retire(1'b1, 32'h0000_0080);
        check("stats_pc", pcCurrent, 32'h0000_0080);
`ifdef PC_FETCH_STATS_EN
        check("stats_retired", retiredCount, 32'd3);
        check("stats_taken",   takenCount,   32'd2);
`else
        check("stats_retired", retiredCount, 32'd0);
        check("stats_taken",   takenCount,   32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
